process_tx_byte: RTL and testbench
==================================

// Module: process_tx_byte
// PURPOSE
// - Transmit-side counterpart of the SIE receive byte processor: turns one packet request into a USB byte stream.
// - Sends SYNC, PID, an optional token field or FIFO data payload, the inverted CRC, then a stop marker.
// - Sits between the host/slave packet controller (request plus TX data FIFO) and the bit-level serial transmitter.
// - Drives the shared CRC5/CRC16 units through the same CRC interface the receive path uses.
// PARAMETERS
// - MAX_DATA_BYTES  1023  payload byte limit per DATA packet; counter is 10 bits
// PORTS
// - clk            in   1   system clock
// - rst            in   1   synchronous, active-low reset
// - txPktStart     in   1   one-cycle packet request; honoured only while txBusy=0
// - txPID          in   4   PID code; [1:0] is the type (SPECIAL/TOKEN/HANDSHAKE/DATA)
// - txTokenData    in   11  token/SOF field: {endp,addr} or frame number
// - txFifoData     in   8   TX FIFO head byte
// - txFifoEmpty    in   1   TX FIFO empty flag
// - txFifoRdEn     out  1   one-cycle pop of the FIFO head byte
// - TxByteOut      out  8   byte to the serial transmitter
// - TxCtrlOut      out  8   DATA_START / DATA_STREAM / DATA_STOP
// - TxByteWEn      out  1   one-cycle write strobe for TxByteOut/TxCtrlOut
// - TxByteRdy      in   1   serial transmitter can accept a byte
// - rstCRC, CRC5En, CRC5_8Bit, CRC16En  out  1 each   CRC control, same meaning as on the receive path
// - CRCData        out  8   CRC update data
// - CRC5Result in 5, CRC16Result in 16, CRC5UpdateRdy in 1, CRC16UpdateRdy in 1   CRC unit status
// - txBusy         out  1   packet in progress
// - txPktDone      out  1   one-cycle pulse after the stop write
// - txDataTrunc    out  1   MAX_DATA_BYTES reached with the FIFO not empty; held until the next txPktStart
// BEHAVIOUR
// - Reset (rst=0 on a clk edge): every output is 0 and the state is IDLE. A reset mid-packet aborts immediately; no stop byte is sent.
// - IDLE: on txPktStart, latch txPID and txTokenData; txBusy=1 from the next cycle; clear txDataTrunc.
// - Byte write rule (WR):
//   - wait until TxByteRdy=1, then pulse TxByteWEn with the byte and ctrl;
//   - the next cycle is a guard cycle in which TxByteRdy is not sampled.
// - CRC update rule (CU):
//   - pulse CRCxEn for one cycle with CRCData;
//   - skip one guard cycle, then wait for CRCxUpdateRdy=1.
// - Sequence:
//   - SYNC: WR {SYNC_BYTE, DATA_START}; rstCRC pulses for 1 cycle in the same cycle.
//   - PID: WR {{~txPID,txPID}, DATA_STREAM}.
//   - Branch on txPID[1:0]: HANDSHAKE/SPECIAL go to STOP; TOKEN goes to TOK; DATA goes to DAT.
//   - TOK:
//     - CU CRC5 with CRC5_8Bit=1, CRCData=tok[7:0]; WR {tok[7:0]};
//     - CU CRC5 with CRC5_8Bit=0, CRCData={5'b0,tok[10:8]}; WR {{~CRC5Result,tok[10:8]}}; then STOP.
//   - DAT:
//     - txFifoEmpty=0 and count<MAX_DATA_BYTES: pulse txFifoRdEn, latch the byte, CU CRC16, WR the byte, count+1, repeat.
//     - txFifoEmpty=1: go to CRC.
//     - count==MAX_DATA_BYTES and txFifoEmpty=0: set txDataTrunc, go to CRC.
//   - CRC: WR ~CRC16Result[7:0], then WR ~CRC16Result[15:8], both DATA_STREAM.
//   - STOP: WR {8'h00, DATA_STOP}; next cycle pulse txPktDone, txBusy=0, state IDLE.
// - Simultaneous events:
//   - txPktStart while txBusy=1 is ignored.
//   - txFifoEmpty is sampled only in the DAT decision cycle; a byte written after that waits for the next packet.
// - Zero-length DATA is legal: the CRC bytes are 00 00 (CRC16 init FFFF, inverted).
// - Data and CRC bytes use ctrl DATA_STREAM; only SYNC uses DATA_START.
// - CRCData, CRC5_8Bit and TxByteOut hold their last value between strobes.
// - Count arithmetic is 10-bit; the count clears at SYNC.
// STRUCTURE
// - Shared headers (usbSerialInterfaceEngine_h / usbConstants_h) hold SYNC_BYTE, DATA_START/STREAM/STOP and the PID types SPECIAL/TOKEN/HANDSHAKE/DATA.
// - TX state codes are local defines, binary encoded, with registered outputs from a next_* combinational block.
// - No sub-module: the WR/CU handshakes are inline wait states.
// TESTING
// - ACK, txPID=4'h2: writes 80/START, D2/STREAM, 00/STOP; txPktDone 1 cycle later.
// - DATA0, txPID=4'h3, FIFO empty: writes 80, C3, 00, 00, then 00/STOP; no txFifoRdEn.
// - SETUP, txPID=4'hD, tok=11'h000: writes 80, 2D, 00, 10, STOP; CRC5En pulses twice (8-bit then 3-bit).
// - MAX_DATA_BYTES=8 with 10 FIFO bytes 01..0A: 8 pops, payload 01..08, txDataTrunc=1, CRC matches the model.
// - Hold TxByteRdy=0 for 5 cycles mid-payload: no TxByteWEn and no second pop; TxByteOut is stable.
// - rst=0 during the payload: next cycle all outputs are 0 and state is IDLE; a new ACK request completes normally.

Source files
------------

// File: rtl/process_tx_byte_pkg.sv
// Shared constants and types for the SIE transmit byte processor.
package process_tx_byte_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned TOK_W  = 11;
  localparam int unsigned PID_W  = 4;

  localparam logic [BYTE_W-1:0] SYNC_BYTE   = 8'h80;
  localparam logic [BYTE_W-1:0] DATA_STOP   = 8'h00;
  localparam logic [BYTE_W-1:0] DATA_START  = 8'h01;
  localparam logic [BYTE_W-1:0] DATA_STREAM = 8'h02;

  typedef enum logic [1:0] {
    PID_SPECIAL   = 2'd0,
    PID_TOKEN     = 2'd1,
    PID_HANDSHAKE = 2'd2,
    PID_DATA      = 2'd3
  } pid_type_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SYNC_WR  = 4'd1,
    ST_PID_WR   = 4'd2,
    ST_TOK1_CRC = 4'd3,
    ST_TOK1_CW  = 4'd4,
    ST_TOK1_WR  = 4'd5,
    ST_TOK2_CRC = 4'd6,
    ST_TOK2_CW  = 4'd7,
    ST_TOK2_WR  = 4'd8,
    ST_DAT_DEC  = 4'd9,
    ST_DAT_CW   = 4'd10,
    ST_DAT_WR   = 4'd11,
    ST_CRC_LO   = 4'd12,
    ST_CRC_HI   = 4'd13,
    ST_STOP_WR  = 4'd14,
    ST_DONE     = 4'd15
  } tx_state_e;

  // One byte handed to the serial transmitter together with its framing code.
  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic [BYTE_W-1:0] ctrl;
  } tx_byte_t;

  function automatic logic [BYTE_W-1:0] pid_byte(input logic [PID_W-1:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/process_tx_byte.sv
// Transmit byte processor: turns one packet request into SYNC, PID, token or
// FIFO payload, inverted CRC and a stop marker for the serial transmitter.
module process_tx_byte
  import process_tx_byte_pkg::*;
#(
  parameter int unsigned MAX_DATA_BYTES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              txPktStart,
  input  logic [PID_W-1:0]  txPID,
  input  logic [TOK_W-1:0]  txTokenData,
  input  logic [BYTE_W-1:0] txFifoData,
  input  logic              txFifoEmpty,
  output logic              txFifoRdEn,
  output logic [BYTE_W-1:0] TxByteOut,
  output logic [BYTE_W-1:0] TxCtrlOut,
  output logic              TxByteWEn,
  input  logic              TxByteRdy,
  output logic              rstCRC,
  output logic              CRC5En,
  output logic              CRC5_8Bit,
  output logic              CRC16En,
  output logic [BYTE_W-1:0] CRCData,
  input  logic [4:0]        CRC5Result,
  input  logic [15:0]       CRC16Result,
  input  logic              CRC5UpdateRdy,
  input  logic              CRC16UpdateRdy,
  output logic              txBusy,
  output logic              txPktDone,
  output logic              txDataTrunc
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA_BYTES);

  tx_state_e         state, state_n;
  tx_byte_t          tx_q, tx_n;
  logic [PID_W-1:0]  pid_q, pid_n;
  logic [TOK_W-1:0]  tok_q, tok_n;
  logic [BYTE_W-1:0] data_q, data_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [BYTE_W-1:0] crc_data_q, crc_data_n;
  logic wen_q, wen_n, rd_q, rd_n, rst_crc_q, rst_crc_n;
  logic crc5_en_q, crc5_en_n, crc16_en_q, crc16_en_n, crc5_8_q, crc5_8_n;
  logic busy_q, busy_n, done_q, done_n, trunc_q, trunc_n;

  // While a strobe is on the wire the peer's ready flag is still stale.
  logic guard, wr_ok;
  assign guard = wen_q | crc5_en_q | crc16_en_q;
  assign wr_ok = TxByteRdy & ~guard;

  always_comb begin
    state_n    = state;
    tx_n       = tx_q;
    pid_n      = pid_q;
    tok_n      = tok_q;
    data_n     = data_q;
    cnt_n      = cnt_q;
    crc_data_n = crc_data_q;
    crc5_8_n   = crc5_8_q;
    busy_n     = busy_q;
    trunc_n    = trunc_q;
    wen_n      = 1'b0;
    rd_n       = 1'b0;
    rst_crc_n  = 1'b0;
    crc5_en_n  = 1'b0;
    crc16_en_n = 1'b0;
    done_n     = 1'b0;
    unique case (state)
      ST_IDLE: if (txPktStart) begin
        pid_n   = txPID;
        tok_n   = txTokenData;
        busy_n  = 1'b1;
        trunc_n = 1'b0;
        state_n = ST_SYNC_WR;
      end
      ST_SYNC_WR: if (wr_ok) begin
        tx_n      = '{data: SYNC_BYTE, ctrl: DATA_START};
        wen_n     = 1'b1;
        rst_crc_n = 1'b1;
        cnt_n     = '0;
        state_n   = ST_PID_WR;
      end
      ST_PID_WR: if (wr_ok) begin
        tx_n  = '{data: pid_byte(pid_q), ctrl: DATA_STREAM};
        wen_n = 1'b1;
        unique case (pid_type_e'(pid_q[1:0]))
          PID_TOKEN: state_n = ST_TOK1_CRC;
          PID_DATA:  state_n = ST_DAT_DEC;
          default:   state_n = ST_STOP_WR;
        endcase
      end
      ST_TOK1_CRC: begin
        crc5_en_n  = 1'b1;
        crc5_8_n   = 1'b1;
        crc_data_n = tok_q[7:0];
        state_n    = ST_TOK1_CW;
      end
      ST_TOK1_CW: if (!guard && CRC5UpdateRdy) state_n = ST_TOK1_WR;
      ST_TOK1_WR: if (wr_ok) begin
        tx_n    = '{data: tok_q[7:0], ctrl: DATA_STREAM};
        wen_n   = 1'b1;
        state_n = ST_TOK2_CRC;
      end
      ST_TOK2_CRC: begin
        crc5_en_n  = 1'b1;
        crc5_8_n   = 1'b0;
        crc_data_n = {5'b0, tok_q[10:8]};
        state_n    = ST_TOK2_CW;
      end
      ST_TOK2_CW: if (!guard && CRC5UpdateRdy) state_n = ST_TOK2_WR;
      ST_TOK2_WR: if (wr_ok) begin
        tx_n    = '{data: {~CRC5Result, tok_q[10:8]}, ctrl: DATA_STREAM};
        wen_n   = 1'b1;
        state_n = ST_STOP_WR;
      end
      // Pop, latch and start the CRC16 update in the same decision cycle.
      ST_DAT_DEC: begin
        if (txFifoEmpty) begin
          state_n = ST_CRC_LO;
        end else if (cnt_q < MAX_CNT) begin
          rd_n       = 1'b1;
          data_n     = txFifoData;
          crc16_en_n = 1'b1;
          crc_data_n = txFifoData;
          state_n    = ST_DAT_CW;
        end else begin
          trunc_n = 1'b1;
          state_n = ST_CRC_LO;
        end
      end
      ST_DAT_CW: if (!guard && CRC16UpdateRdy) state_n = ST_DAT_WR;
      ST_DAT_WR: if (wr_ok) begin
        tx_n    = '{data: data_q, ctrl: DATA_STREAM};
        wen_n   = 1'b1;
        cnt_n   = cnt_q + CNT_W'(1);
        state_n = ST_DAT_DEC;
      end
      ST_CRC_LO: if (wr_ok) begin
        tx_n    = '{data: ~CRC16Result[7:0], ctrl: DATA_STREAM};
        wen_n   = 1'b1;
        state_n = ST_CRC_HI;
      end
      ST_CRC_HI: if (wr_ok) begin
        tx_n    = '{data: ~CRC16Result[15:8], ctrl: DATA_STREAM};
        wen_n   = 1'b1;
        state_n = ST_STOP_WR;
      end
      ST_STOP_WR: if (wr_ok) begin
        tx_n    = '{data: 8'h00, ctrl: DATA_STOP};
        wen_n   = 1'b1;
        state_n = ST_DONE;
      end
      ST_DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tx_q       <= '0;
      pid_q      <= '0;
      tok_q      <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      crc_data_q <= '0;
      crc5_8_q   <= 1'b0;
      busy_q     <= 1'b0;
      trunc_q    <= 1'b0;
      wen_q      <= 1'b0;
      rd_q       <= 1'b0;
      rst_crc_q  <= 1'b0;
      crc5_en_q  <= 1'b0;
      crc16_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      tx_q       <= tx_n;
      pid_q      <= pid_n;
      tok_q      <= tok_n;
      data_q     <= data_n;
      cnt_q      <= cnt_n;
      crc_data_q <= crc_data_n;
      crc5_8_q   <= crc5_8_n;
      busy_q     <= busy_n;
      trunc_q    <= trunc_n;
      wen_q      <= wen_n;
      rd_q       <= rd_n;
      rst_crc_q  <= rst_crc_n;
      crc5_en_q  <= crc5_en_n;
      crc16_en_q <= crc16_en_n;
      done_q     <= done_n;
    end
  end

  assign TxByteOut   = tx_q.data;
  assign TxCtrlOut   = tx_q.ctrl;
  assign TxByteWEn   = wen_q;
  assign txFifoRdEn  = rd_q;
  assign rstCRC      = rst_crc_q;
  assign CRC5En      = crc5_en_q;
  assign CRC5_8Bit   = crc5_8_q;
  assign CRC16En     = crc16_en_q;
  assign CRCData     = crc_data_q;
  assign txBusy      = busy_q;
  assign txPktDone   = done_q;
  assign txDataTrunc = trunc_q;

endmodule

// File: tb/tb_process_tx_byte.sv
// Bench for process_tx_byte: FIFO, serial transmitter and CRC unit models with
// an expected-byte scoreboard.
module tb_process_tx_byte;
  import process_tx_byte_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        txPktStart;
  logic [3:0]  txPID;
  logic [10:0] txTokenData;
  logic [7:0]  txFifoData;
  logic        txFifoEmpty;
  logic        txFifoRdEn;
  logic [7:0]  TxByteOut, TxCtrlOut;
  logic        TxByteWEn, TxByteRdy;
  logic        rstCRC, CRC5En, CRC5_8Bit, CRC16En;
  logic [7:0]  CRCData;
  logic [4:0]  CRC5Result;
  logic [15:0] CRC16Result;
  logic        CRC5UpdateRdy, CRC16UpdateRdy;
  logic        txBusy, txPktDone, txDataTrunc;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  process_tx_byte #(.MAX_DATA_BYTES(8)) dut (
    .clk(clk), .rst(rst), .txPktStart(txPktStart), .txPID(txPID),
    .txTokenData(txTokenData), .txFifoData(txFifoData), .txFifoEmpty(txFifoEmpty),
    .txFifoRdEn(txFifoRdEn), .TxByteOut(TxByteOut), .TxCtrlOut(TxCtrlOut),
    .TxByteWEn(TxByteWEn), .TxByteRdy(TxByteRdy), .rstCRC(rstCRC), .CRC5En(CRC5En),
    .CRC5_8Bit(CRC5_8Bit), .CRC16En(CRC16En), .CRCData(CRCData),
    .CRC5Result(CRC5Result), .CRC16Result(CRC16Result),
    .CRC5UpdateRdy(CRC5UpdateRdy), .CRC16UpdateRdy(CRC16UpdateRdy),
    .txBusy(txBusy), .txPktDone(txPktDone), .txDataTrunc(txDataTrunc)
  );

  // ---------------- reference CRCs (USB, LSB first, reflected polynomials)
  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic [7:0] d, input int nbits);
    logic [4:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < nbits; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 5'h14;
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  // ---------------- FIFO model
  logic [7:0] fifo_mem [0:255];
  logic [7:0] fifo_wr = 8'd0;
  logic [7:0] fifo_rd = 8'd0;
  int         pops = 0;
  assign txFifoData  = fifo_mem[fifo_rd];
  assign txFifoEmpty = (fifo_rd == fifo_wr);
  always @(posedge clk) if (txFifoRdEn) begin
    fifo_rd <= fifo_rd + 8'd1;
    pops    <= pops + 1;
  end

  // ---------------- serial transmitter model: busy two cycles after each write
  int   tx_bsy  = 0;
  logic tx_hold = 1'b0;
  assign TxByteRdy = (tx_bsy == 0) && !tx_hold;
  always @(posedge clk) begin
    if (TxByteWEn) tx_bsy <= 2;
    else if (tx_bsy > 0) tx_bsy <= tx_bsy - 1;
  end

  // ---------------- CRC unit model: result updates at once, ready drops 3 cycles
  logic [4:0]  crc5_r;
  logic [15:0] crc16_r;
  int c5_cnt, c16_cnt;
  int crc5_pulses = 0;
  assign CRC5Result  = crc5_r;
  assign CRC16Result = crc16_r;
  always @(posedge clk) begin
    if (!rst) begin
      crc5_r <= 5'h1F; crc16_r <= 16'hFFFF;
      CRC5UpdateRdy <= 1'b1; CRC16UpdateRdy <= 1'b1; c5_cnt <= 0; c16_cnt <= 0;
    end else begin
      if (rstCRC) begin
        crc5_r <= 5'h1F; crc16_r <= 16'hFFFF;
      end
      if (CRC5En) begin
        crc5_r <= crc5_step(crc5_r, CRCData, CRC5_8Bit ? 8 : 3);
        CRC5UpdateRdy <= 1'b0; c5_cnt <= 3;
        crc5_pulses <= crc5_pulses + 1;
      end else if (c5_cnt > 0) begin
        c5_cnt <= c5_cnt - 1;
        if (c5_cnt == 1) CRC5UpdateRdy <= 1'b1;
      end
      if (CRC16En) begin
        crc16_r <= crc16_step(crc16_r, CRCData);
        CRC16UpdateRdy <= 1'b0; c16_cnt <= 3;
      end else if (c16_cnt > 0) begin
        c16_cnt <= c16_cnt - 1;
        if (c16_cnt == 1) CRC16UpdateRdy <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  always @(negedge clk) if (TxByteWEn) obs_q.push_back({TxByteOut, TxCtrlOut});

  task automatic push_data(input logic [3:0] pid, input logic [7:0] pl [$]);
    logic [15:0] c;
    c = 16'hFFFF;
    exp_q.push_back({SYNC_BYTE, DATA_START});
    exp_q.push_back({{~pid, pid}, DATA_STREAM});
    foreach (pl[i]) begin
      exp_q.push_back({pl[i], DATA_STREAM});
      c = crc16_step(c, pl[i]);
    end
    exp_q.push_back({~c[7:0], DATA_STREAM});
    exp_q.push_back({~c[15:8], DATA_STREAM});
    exp_q.push_back({8'h00, DATA_STOP});
  endtask

  task automatic send_req(input logic [3:0] pid, input logic [10:0] tok);
    @(negedge clk);
    txPID = pid; txTokenData = tok; txPktStart = 1'b1;
    @(negedge clk);
    txPktStart = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int gap);
    int stop_at;
    stop_at = -1;
    gap = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (TxByteWEn && TxCtrlOut == DATA_STOP) stop_at = c;
      if (txPktDone) begin
        gap = (stop_at < 0) ? -2 : c - stop_at;
        break;
      end
    end
  endtask

  task automatic fifo_load(input logic [7:0] pl [$]);
    fifo_wr = fifo_rd;
    foreach (pl[i]) begin
      fifo_mem[fifo_wr] = pl[i];
      fifo_wr = fifo_wr + 8'd1;
    end
  endtask

  // ---------------- tests
  task automatic test_reset();
    rst = 1'b0; txPktStart = 1'b0; txPID = '0; txTokenData = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({TxByteWEn, txFifoRdEn, rstCRC, CRC5En, CRC16En, CRC5_8Bit} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes got=%b exp=000000",
        {TxByteWEn, txFifoRdEn, rstCRC, CRC5En, CRC16En, CRC5_8Bit});
    end
    n_vec++;
    if ({TxByteOut, TxCtrlOut, CRCData} !== 24'h0) begin
      n_fail++; $display("FAIL reset_buses got=%h exp=000000", {TxByteOut, TxCtrlOut, CRCData});
    end
    n_vec++;
    if ({txBusy, txPktDone, txDataTrunc} !== 3'b000) begin
      n_fail++; $display("FAIL reset_status got=%b exp=000", {txBusy, txPktDone, txDataTrunc});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ack();
    int gap;
    logic [15:0] e, o;
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({SYNC_BYTE, DATA_START});
    exp_q.push_back({8'hD2, DATA_STREAM});
    exp_q.push_back({8'h00, DATA_STOP});
    send_req(4'h2, 11'h0);
    n_vec++;
    if (txBusy !== 1'b1) begin n_fail++; $display("FAIL ack_busy got=%b exp=1", txBusy); end
    // a request while busy must be ignored
    send_req(4'h3, 11'h0);
    wait_done(200, gap);
    n_vec++;
    if (gap !== 1) begin n_fail++; $display("FAIL ack_done_gap got=%0d exp=1", gap); end
    n_vec++;
    if (txBusy !== 1'b0) begin n_fail++; $display("FAIL ack_busy_end got=%b exp=0", txBusy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL ack_byte missing exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL ack_byte got=%h exp=%h", o, e); end
      end
    end
    repeat (30) @(negedge clk);
    n_vec++;
    if (obs_q.size() != 0 || txBusy !== 1'b0) begin
      n_fail++; $display("FAIL ack_ignored_start extra_writes=%0d busy=%b exp=0/0", obs_q.size(), txBusy);
    end
  endtask

  task automatic test_data_empty();
    int gap, p0;
    logic [15:0] e, o;
    logic [7:0] none [$];
    exp_q.delete(); obs_q.delete();
    fifo_load(none);
    push_data(4'h3, none);
    p0 = pops;
    send_req(4'h3, 11'h0);
    wait_done(300, gap);
    n_vec++;
    if (gap !== 1) begin n_fail++; $display("FAIL zlen_done_gap got=%0d exp=1", gap); end
    n_vec++;
    if (pops - p0 !== 0) begin n_fail++; $display("FAIL zlen_pops got=%0d exp=0", pops - p0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL zlen_byte missing exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL zlen_byte got=%h exp=%h", o, e); end
      end
    end
  endtask

  task automatic test_token(input logic [3:0] pid, input logic [10:0] tok);
    int gap, c0;
    logic [4:0] c;
    logic [15:0] e, o;
    exp_q.delete(); obs_q.delete();
    c = crc5_step(5'h1F, tok[7:0], 8);
    c = crc5_step(c, {5'b0, tok[10:8]}, 3);
    exp_q.push_back({SYNC_BYTE, DATA_START});
    exp_q.push_back({{~pid, pid}, DATA_STREAM});
    exp_q.push_back({tok[7:0], DATA_STREAM});
    exp_q.push_back({{~c, tok[10:8]}, DATA_STREAM});
    exp_q.push_back({8'h00, DATA_STOP});
    c0 = crc5_pulses;
    send_req(pid, tok);
    wait_done(300, gap);
    n_vec++;
    if (crc5_pulses - c0 !== 2) begin
      n_fail++; $display("FAIL tok_crc5_pulses got=%0d exp=2", crc5_pulses - c0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL tok_byte missing exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL tok_byte got=%h exp=%h", o, e); end
      end
    end
  endtask

  task automatic test_trunc();
    int gap, p0;
    logic [15:0] e, o;
    logic [7:0] pl [$];
    logic [7:0] sent [$];
    exp_q.delete(); obs_q.delete();
    for (int i = 1; i <= 10; i++) pl.push_back(8'(i));
    for (int i = 1; i <= 8; i++) sent.push_back(8'(i));
    fifo_load(pl);
    push_data(4'hB, sent);
    p0 = pops;
    send_req(4'hB, 11'h0);
    wait_done(2000, gap);
    n_vec++;
    if (pops - p0 !== 8) begin n_fail++; $display("FAIL trunc_pops got=%0d exp=8", pops - p0); end
    n_vec++;
    if (txDataTrunc !== 1'b1) begin n_fail++; $display("FAIL trunc_flag got=%b exp=1", txDataTrunc); end
    n_vec++;
    if (int'(fifo_wr - fifo_rd) !== 2) begin
      n_fail++; $display("FAIL trunc_left got=%0d exp=2", int'(fifo_wr - fifo_rd));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL trunc_byte missing exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL trunc_byte got=%h exp=%h", o, e); end
      end
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (txDataTrunc !== 1'b1) begin n_fail++; $display("FAIL trunc_hold got=%b exp=1", txDataTrunc); end
    send_req(4'h2, 11'h0);
    n_vec++;
    if (txDataTrunc !== 1'b0) begin n_fail++; $display("FAIL trunc_clear got=%b exp=0", txDataTrunc); end
    wait_done(200, gap);
    fifo_wr = fifo_rd;
  endtask

  task automatic test_stall();
    int gap, p_snap, wr_seen;
    logic [7:0] out_snap;
    logic [15:0] e, o;
    logic [7:0] pl [$];
    exp_q.delete(); obs_q.delete();
    pl = '{8'h11, 8'h22, 8'h33};
    fifo_load(pl);
    push_data(4'h3, pl);
    send_req(4'h3, 11'h0);
    wr_seen = 0;
    for (int c = 0; c < 300 && wr_seen < 3; c++) begin
      @(negedge clk);
      if (TxByteWEn) wr_seen++;
    end
    tx_hold = 1'b1;
    repeat (2) @(negedge clk);
    p_snap = pops; out_snap = TxByteOut;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (TxByteWEn !== 1'b0) begin n_fail++; $display("FAIL stall_wen cyc=%0d got=%b exp=0", c, TxByteWEn); end
    end
    n_vec++;
    if (pops !== p_snap) begin n_fail++; $display("FAIL stall_pops got=%0d exp=%0d", pops, p_snap); end
    n_vec++;
    if (TxByteOut !== out_snap) begin n_fail++; $display("FAIL stall_out got=%h exp=%h", TxByteOut, out_snap); end
    tx_hold = 1'b0;
    wait_done(500, gap);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL stall_byte missing exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL stall_byte got=%h exp=%h", o, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int gap, wr_seen;
    logic [15:0] e, o;
    logic [7:0] pl [$];
    pl = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    fifo_load(pl);
    send_req(4'h3, 11'h0);
    wr_seen = 0;
    for (int c = 0; c < 300 && wr_seen < 3; c++) begin
      @(negedge clk);
      if (TxByteWEn) wr_seen++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({txBusy, TxByteWEn, txFifoRdEn, CRC16En, TxByteOut, TxCtrlOut} !== 20'h0) begin
      n_fail++; $display("FAIL midrst_outputs got=%h exp=00000",
        {txBusy, TxByteWEn, txFifoRdEn, CRC16En, TxByteOut, TxCtrlOut});
    end
    rst = 1'b1;
    fifo_wr = fifo_rd;
    repeat (5) @(negedge clk);
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({SYNC_BYTE, DATA_START});
    exp_q.push_back({8'hD2, DATA_STREAM});
    exp_q.push_back({8'h00, DATA_STOP});
    send_req(4'h2, 11'h0);
    wait_done(200, gap);
    n_vec++;
    if (gap !== 1) begin n_fail++; $display("FAIL midrst_ack_gap got=%0d exp=1", gap); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL midrst_byte missing exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL midrst_byte got=%h exp=%h", o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_data_empty();
    test_token(4'hD, 11'h000);
    test_token(4'h1, 11'h3A5);
    test_trunc();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1);
  end

endmodule
